tile_scanner: RTL and testbench

Pixel-pipeline stage between the VGA controller and the glyph ROM. It holds a 26×21 tilemap of 4-bit glyph codes written by game logic. It tracks tile column/row and intra-tile offsets with counters rather than dividers, drives the glyph ROM address, and returns a per-pixel on/off bit plus the glyph code to the colour mapper.

---
 rtl/tile_pkg.sv | 50 +++++
 rtl/tilemap_ram.sv | 31 +++
 rtl/tile_scanner.sv | 160 ++++++++++++++++
 tb/tb_tile_scanner.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Geometry constants and glyph codes for the tile scanner.
// Define TILE_MIRROR_EN to store a per-tile horizontal mirror bit.
package tile_pkg;

    localparam int TILE_W     = 24;
    localparam int TILE_H     = 22;
    localparam int GRID_COLS  = 26;
    localparam int GRID_ROWS  = 21;
    localparam int NUM_GLYPHS = 13;
    localparam int MAP_DEPTH  = GRID_COLS * GRID_ROWS;

`ifdef TILE_MIRROR_EN
    localparam int MAP_W = 5;
`else
    localparam int MAP_W = 4;
`endif

    localparam logic [4:0] SUBX_LAST = 5'(TILE_W - 1);
    localparam logic [4:0] SUBY_LAST = 5'(TILE_H - 1);
    localparam logic [4:0] COL_END   = 5'(GRID_COLS);
    localparam logic [4:0] ROW_END   = 5'(GRID_ROWS);
    localparam logic [9:0] LINE_STEP = 10'(GRID_COLS);
    localparam logic [3:0] GLYPH_END = 4'(NUM_GLYPHS);

    typedef enum logic [3:0] {
        BLANK     = 4'd0,
        FROG_UP   = 4'd1,
        FROG_DOWN = 4'd2,
        FROG_R    = 4'd3,
        FROG_L    = 4'd4,
        S         = 4'd5,
        C         = 4'd6,
        O         = 4'd7,
        R         = 4'd8,
        E         = 4'd9,
        COLON     = 4'd10,
        ZERO      = 4'd11,
        SOLID     = 4'd12
    } glyph_t;

    // code * 22 + suby as 16 + 4 + 2 shifts
    function automatic logic [10:0] glyph_row_addr(
        input logic [3:0] code,
        input logic [4:0] suby
    );
        return {3'd0, code, 4'd0} + {5'd0, code, 2'd0}
             + {6'd0, code, 1'b0} + {6'd0, suby};
    endfunction

endpackage

// File: rtl/tilemap_ram.sv
// 546-entry tilemap: one write port, one registered read port.
// Read-first on a same-address collision; contents are not reset.
module tilemap_ram
    import tile_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [9:0]       wr_addr,
    input  logic [MAP_W-1:0] wr_data,
    input  logic [9:0]       rd_addr,
    output logic [MAP_W-1:0] rd_data
);

    logic [MAP_W-1:0] mem_q [0:MAP_DEPTH-1];
    logic [MAP_W-1:0] rd_data_q;
    logic [MAP_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tile_scanner.sv
// Three-stage tile scanner: counters -> tilemap read -> glyph bit select.
// TILE_MIRROR_EN adds a stored per-tile horizontal mirror bit.
module tile_scanner
    import tile_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid_in,
    input  logic        wr_en,
    input  logic [4:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [3:0]  wr_code,
    input  logic        wr_mirror,
    output logic [10:0] font_addr,
    input  logic [23:0] font_data,
    output logic        pixel_on,
    output logic [3:0]  pixel_code,
    output logic        pix_valid_out
);

    // stage 1: the counters double as the stage-1 position registers
    logic [4:0] col_q, col_d, subx_q, subx_d;
    logic [4:0] row_q, row_d, suby_q, suby_d;
    logic [9:0] lb_q, lb_d;
    logic       s1_valid_q;
    logic       s1_in_q, s1_in_d;
    logic [9:0] s1_addr_q, s1_addr_d;

    logic       s2_valid_q, s2_in_q;
    logic [4:0] s2_subx_q, s2_suby_q;

    logic       on_q, on_d;
    logic [3:0] code_q, code_d;
    logic       vout_q, vout_d;

    logic [MAP_W-1:0] wr_data;
    logic [MAP_W-1:0] rd_data;
    logic [9:0]       wr_addr;
    logic             wr_ok;
    logic [3:0]       code_eff;
    logic             mir;
    logic             legal;
    logic [4:0]       bit_idx;

`ifdef TILE_MIRROR_EN
    assign wr_data = {wr_mirror, wr_code};
`else
    logic unused_mirror;
    assign unused_mirror = wr_mirror;
    assign wr_data       = wr_code;
`endif

    assign wr_ok   = wr_en && (wr_col < COL_END) && (wr_row < ROW_END);
    assign wr_addr = {1'b0, wr_row, 4'd0} + {2'd0, wr_row, 3'd0}
                   + {4'd0, wr_row, 1'b0} + {5'd0, wr_col};

    always_comb begin
        col_d  = col_q;
        subx_d = subx_q;
        row_d  = row_q;
        suby_d = suby_q;
        lb_d   = lb_q;
        if (pix_valid_in) begin
            if (DrawX == 10'd0) begin
                col_d  = 5'd0;
                subx_d = 5'd0;
                if (DrawY == 10'd0) begin
                    row_d  = 5'd0;
                    suby_d = 5'd0;
                    lb_d   = 10'd0;
                end else if (suby_q == SUBY_LAST) begin
                    suby_d = 5'd0;
                    if (row_q != ROW_END) begin
                        row_d = row_q + 5'd1;
                        lb_d  = lb_q + LINE_STEP;
                    end
                end else begin
                    suby_d = suby_q + 5'd1;
                end
            end else if (subx_q == SUBX_LAST) begin
                subx_d = 5'd0;
                if (col_q != COL_END) begin
                    col_d = col_q + 5'd1;
                end
            end else begin
                subx_d = subx_q + 5'd1;
            end
        end
        s1_in_d   = (col_d < COL_END) && (row_d < ROW_END);
        s1_addr_d = s1_in_d ? (lb_d + {5'd0, col_d}) : 10'd0;
    end

    tilemap_ram u_map (
        .clk     (Clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (s1_addr_q),
        .rd_data (rd_data)
    );

    // gating keeps font_addr at 0 out of reset even though the RAM is not reset
    always_comb begin
        code_eff = (s2_valid_q && s2_in_q) ? rd_data[3:0] : 4'd0;
`ifdef TILE_MIRROR_EN
        mir = rd_data[4];
`else
        mir = 1'b0;
`endif
        legal     = code_eff < GLYPH_END;
        font_addr = legal ? glyph_row_addr(code_eff, s2_suby_q) : 11'd0;
        bit_idx   = mir ? s2_subx_q : (SUBX_LAST - s2_subx_q);
        on_d      = s2_valid_q && s2_in_q && legal && font_data[bit_idx];
        code_d    = code_eff;
        vout_d    = s2_valid_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q      <= '0;
            subx_q     <= '0;
            row_q      <= '0;
            suby_q     <= '0;
            lb_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_in_q    <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_in_q    <= 1'b0;
            s2_subx_q  <= '0;
            s2_suby_q  <= '0;
            on_q       <= 1'b0;
            code_q     <= '0;
            vout_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            subx_q     <= subx_d;
            row_q      <= row_d;
            suby_q     <= suby_d;
            lb_q       <= lb_d;
            s1_valid_q <= pix_valid_in;
            s1_in_q    <= s1_in_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s1_valid_q;
            s2_in_q    <= s1_in_q;
            s2_subx_q  <= subx_q;
            s2_suby_q  <= suby_q;
            on_q       <= on_d;
            code_q     <= code_d;
            vout_q     <= vout_d;
        end
    end

    assign pixel_on      = on_q;
    assign pixel_code    = code_q;
    assign pix_valid_out = vout_q;

endmodule

// File: tb/tb_tile_scanner.sv
// Self-checking bench for tile_scanner: random tilemap and scans
// compared against a divide/modulo reference model of the tile grid.
module tb_tile_scanner;

    localparam int N = 1 << 17;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        pix_valid_in, wr_en;
    logic [4:0]  wr_col, wr_row;
    logic [3:0]  wr_code;
    logic        wr_mirror;
    logic [10:0] font_addr;
    logic [23:0] font_data;
    logic        pixel_on;
    logic [3:0]  pixel_code;
    logic        pix_valid_out;

    logic [23:0] font_rom [0:2047];
    assign font_data = font_rom[font_addr];

    always #5 Clk = ~Clk;

    tile_scanner dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pix_valid_in  (pix_valid_in),
        .wr_en         (wr_en),
        .wr_col        (wr_col),
        .wr_row        (wr_row),
        .wr_code       (wr_code),
        .wr_mirror     (wr_mirror),
        .font_addr     (font_addr),
        .font_data     (font_data),
        .pixel_on      (pixel_on),
        .pixel_code    (pixel_code),
        .pix_valid_out (pix_valid_out)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int edge_cnt = 0;

    logic        obs_v    [0:N-1];
    logic        obs_on   [0:N-1];
    logic [3:0]  obs_code [0:N-1];
    logic [10:0] obs_fa   [0:N-1];

    bit exp_v  [0:N-1];
    bit exp_on [0:N-1];
    bit exp_fg [0:N-1];
    int exp_code [0:N-1];
    int exp_fa   [0:N-1];
    int bx [0:N-1];
    int by [0:N-1];
    int beats [$];

    int map_code [0:20][0:25];
    bit map_mir  [0:20][0:25];

    // output log, indexed by the clock edge just taken
    always @(posedge Clk) begin
        edge_cnt = edge_cnt + 1;
        #1;
        if (edge_cnt < N) begin
            obs_v[edge_cnt]    = pix_valid_out;
            obs_on[edge_cnt]   = pixel_on;
            obs_code[edge_cnt] = pixel_code;
            obs_fa[edge_cnt]   = font_addr;
        end
    end

    task automatic drive(input int x, input int y, input bit v,
                         input bit we = 1'b0, input int wc = 0,
                         input int wr = 0, input int wcode = 0,
                         input bit wm = 1'b0);
        int e, col, row, sx, sy, code, bi;
        bit mir;
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid_in = v;
        wr_en = we;
        wr_col = 5'(wc);
        wr_row = 5'(wr);
        wr_code = 4'(wcode);
        wr_mirror = wm;
        if (we) begin
            map_code[wr][wc] = wcode;
            map_mir[wr][wc]  = wm;
        end
        e = edge_cnt + 1;
        bx[e] = x;
        by[e] = y;
        exp_v[e] = v;
        exp_on[e] = 1'b0;
        exp_fg[e] = 1'b0;
        exp_code[e] = 0;
        exp_fa[e] = 0;
        if (v && x < 624 && y < 462) begin
            col = x / 24;
            row = y / 22;
            sx = x % 24;
            sy = y % 22;
            code = map_code[row][col];
`ifdef TILE_MIRROR_EN
            mir = map_mir[row][col];
`else
            mir = 1'b0;
`endif
            exp_fg[e] = 1'b1;
            exp_code[e] = code;
            if (code < 13) begin
                exp_fa[e] = code * 22 + sy;
                bi = mir ? sx : 23 - sx;
                exp_on[e] = font_rom[exp_fa[e]][bi];
            end
        end
        beats.push_back(e);
    endtask

    task automatic settle();
        @(negedge Clk);
        pix_valid_in = 1'b0;
        wr_en = 1'b0;
        repeat (4) @(posedge Clk);
        #2;
    endtask

    task automatic fill_map();
        for (int r = 0; r < 21; r++)
            for (int c = 0; c < 26; c++)
                drive(0, 0, 0, 1'b1, c, r, $urandom_range(0, 15),
                      1'($urandom_range(0, 1)));
        settle();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        DrawX = '0;
        DrawY = '0;
        pix_valid_in = 1'b0;
        wr_en = 1'b0;
        wr_col = '0;
        wr_row = '0;
        wr_code = '0;
        wr_mirror = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_chk++;
        if (font_addr !== 11'd0) $display("FAIL reset font_addr got %0d want 0", font_addr);
        else n_pass++;
        n_chk++;
        if (pixel_on !== 1'b0) $display("FAIL reset pixel_on got %b want 0", pixel_on);
        else n_pass++;
        n_chk++;
        if (pixel_code !== 4'd0) $display("FAIL reset pixel_code got %0d want 0", pixel_code);
        else n_pass++;
        n_chk++;
        if (pix_valid_out !== 1'b0) $display("FAIL reset pix_valid_out got %b want 0", pix_valid_out);
        else n_pass++;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if (pix_valid_out !== 1'b0 || font_addr !== 11'd0)
            $display("FAIL post_reset got v=%b fa=%0d want v=0 fa=0", pix_valid_out, font_addr);
        else n_pass++;
    endtask

    task automatic test_glyph_line();
        int e0;
        drive(0, 0, 0, 1'b1, 0, 0, 1, 1'b0);
        settle();
        beats.delete();
        for (int x = 0; x < 24; x++) drive(x, 0, 1);
        for (int x = 0; x < 24; x++) drive(x, 1, 1);
        settle();
        e0 = beats[0];
        n_chk++;
        if (obs_v[e0+1] !== 1'b0 || obs_v[e0+2] !== 1'b1)
            $display("FAIL latency got v@2=%b v@3=%b want 0 1", obs_v[e0+1], obs_v[e0+2]);
        else n_pass++;
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e]))
                || (exp_fg[e] && obs_fa[e+1] !== 11'(exp_fa[e])))
                $display("FAIL glyph x=%0d y=%0d got v=%b on=%b code=%0d fa=%0d want v=%b on=%b code=%0d fa=%0d",
                         bx[e], by[e], obs_v[e+2], obs_on[e+2], obs_code[e+2], obs_fa[e+1],
                         exp_v[e], exp_on[e], exp_code[e], exp_fa[e]);
            else n_pass++;
            if (by[e] == 1) begin
                n_chk++;
                if (obs_fa[e+1] !== 11'd23 || obs_on[e+2] !== (bx[e] >= 2 && bx[e] <= 4))
                    $display("FAIL glyph_row1 x=%0d got fa=%0d on=%b want fa=23 on=%b",
                             bx[e], obs_fa[e+1], obs_on[e+2], (bx[e] >= 2 && bx[e] <= 4));
                else n_pass++;
            end
        end
    endtask

    task automatic test_collision();
        drive(0, 0, 0, 1'b1, 1, 0, 7, 1'b0);
        settle();
        beats.delete();
        for (int x = 0; x < 48; x++) begin
            if (x == 25) drive(x, 0, 1, 1'b1, 1, 0, 5, 1'b0);
            else drive(x, 0, 1);
        end
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e])))
                $display("FAIL collision x=%0d got v=%b on=%b code=%0d want v=%b on=%b code=%0d",
                         bx[e], obs_v[e+2], obs_on[e+2], obs_code[e+2],
                         exp_v[e], exp_on[e], exp_code[e]);
            else n_pass++;
            if (bx[e] == 24 || bx[e] == 25) begin
                n_chk++;
                if (obs_code[e+2] !== ((bx[e] == 24) ? 4'd7 : 4'd5))
                    $display("FAIL collision_code x=%0d got %0d want %0d",
                             bx[e], obs_code[e+2], (bx[e] == 24) ? 7 : 5);
                else n_pass++;
            end
        end
    endtask

    task automatic test_illegal();
        drive(0, 0, 0, 1'b1, 3, 3, 14, 1'b0);
        settle();
        beats.delete();
        for (int y = 0; y < 66; y++) drive(0, y, 1);
        for (int y = 66; y < 88; y++)
            for (int x = 0; x < 96; x++) drive(x, y, 1);
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e]))
                || (exp_fg[e] && obs_fa[e+1] !== 11'(exp_fa[e])))
                $display("FAIL illegal_scan x=%0d y=%0d got on=%b code=%0d fa=%0d want on=%b code=%0d fa=%0d",
                         bx[e], by[e], obs_on[e+2], obs_code[e+2], obs_fa[e+1],
                         exp_on[e], exp_code[e], exp_fa[e]);
            else n_pass++;
            if (by[e] >= 66 && bx[e] >= 72) begin
                n_chk++;
                if (obs_fa[e+1] !== 11'd0 || obs_on[e+2] !== 1'b0 || obs_code[e+2] !== 4'd14)
                    $display("FAIL illegal x=%0d y=%0d got fa=%0d on=%b code=%0d want fa=0 on=0 code=14",
                             bx[e], by[e], obs_fa[e+1], obs_on[e+2], obs_code[e+2]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_corner();
        bit want;
        drive(0, 0, 0, 1'b1, 25, 20, 12, 1'b0);
        settle();
        beats.delete();
        for (int y = 0; y < 440; y++) drive(0, y, 1);
        for (int y = 440; y < 466; y++)
            for (int x = 0; x < 640; x++) drive(x, y, 1);
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e])))
                $display("FAIL corner_scan x=%0d y=%0d got on=%b code=%0d want on=%b code=%0d",
                         bx[e], by[e], obs_on[e+2], obs_code[e+2], exp_on[e], exp_code[e]);
            else n_pass++;
            if (bx[e] >= 600) begin
                want = (bx[e] < 624 && by[e] >= 440 && by[e] < 462);
                n_chk++;
                if (obs_on[e+2] !== want || (!want && obs_code[e+2] !== 4'd0 && (bx[e] >= 624 || by[e] >= 462)))
                    $display("FAIL corner x=%0d y=%0d got on=%b code=%0d want on=%b",
                             bx[e], by[e], obs_on[e+2], obs_code[e+2], want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_scan();
        beats.delete();
        for (int y = 0; y < 480; y++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 400) : 1;
            for (int x = 0; x < len; x++) begin
                if ($urandom_range(0, 3) == 0)
                    drive($urandom_range(0, 639), $urandom_range(0, 479), 0);
                drive(x, y, 1);
            end
        end
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e]))
                || (exp_fg[e] && obs_fa[e+1] !== 11'(exp_fa[e])))
                $display("FAIL random x=%0d y=%0d v=%b got v=%b on=%b code=%0d fa=%0d want v=%b on=%b code=%0d fa=%0d",
                         bx[e], by[e], exp_v[e], obs_v[e+2], obs_on[e+2], obs_code[e+2], obs_fa[e+1],
                         exp_v[e], exp_on[e], exp_code[e], exp_fa[e]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        beats.delete();
        for (int y = 0; y < 100; y++) drive(0, y, 1);
        for (int x = 0; x < 51; x++) drive(x, 100, 1);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        pix_valid_in = 1'b0;
        wr_en = 1'b0;
        #1;
        n_chk++;
        if (pixel_on !== 1'b0 || pixel_code !== 4'd0 || pix_valid_out !== 1'b0 || font_addr !== 11'd0)
            $display("FAIL async_reset got on=%b code=%0d v=%b fa=%0d want all 0",
                     pixel_on, pixel_code, pix_valid_out, font_addr);
        else n_pass++;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        beats.delete();
        for (int y = 0; y < 44; y++)
            for (int x = 0; x < 60 + (y % 5) * 20; x++) drive(x, y, 1);
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            n_chk++;
            if (obs_v[e+2] !== exp_v[e] || obs_on[e+2] !== exp_on[e]
                || (exp_v[e] && obs_code[e+2] !== 4'(exp_code[e])))
                $display("FAIL after_reset x=%0d y=%0d got on=%b code=%0d want on=%b code=%0d",
                         bx[e], by[e], obs_on[e+2], obs_code[e+2], exp_on[e], exp_code[e]);
            else n_pass++;
        end
    endtask

    task automatic test_mirror();
        bit want;
        int x;
        drive(0, 0, 0, 1'b1, 0, 0, 3, 1'b1);
        settle();
        beats.delete();
        for (int i = 0; i < 24; i++) drive(i, 0, 1);
        settle();
        foreach (beats[i]) begin
            int e;
            e = beats[i];
            x = bx[e];
`ifdef TILE_MIRROR_EN
            want = (x >= 1 && x <= 6) || (x >= 16 && x <= 22);
`else
            want = (x >= 1 && x <= 7) || (x >= 17 && x <= 22);
`endif
            n_chk++;
            if (obs_on[e+2] !== want || obs_on[e+2] !== exp_on[e] || obs_code[e+2] !== 4'd3)
                $display("FAIL mirror x=%0d got on=%b code=%0d want on=%b code=3",
                         x, obs_on[e+2], obs_code[e+2], want);
            else n_pass++;
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) font_rom[a] = 24'($urandom);
        font_rom[23] = 24'h380000;
        for (int a = 264; a < 286; a++) font_rom[a] = 24'hFFFFFF;
        font_rom[66] = 24'h7F007E;
        test_reset();
        fill_map();
        test_glyph_line();
        test_collision();
        test_illegal();
        test_corner();
        test_random_scan();
        test_reset_mid();
        test_mirror();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
